// File: rtl/ps2_host_cmd_ctrl_pkg.sv
// Shared constants, error codes, FSM state type and frame builder for the PS/2 host command path.
package ps2_host_cmd_ctrl_pkg;

  localparam logic [7:0] PS2_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_CMD_LED   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;

  localparam logic [1:0] ERR_OK          = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT     = 2'b01;
  localparam logic [1:0] ERR_NO_LINE_ACK = 2'b10;
  localparam logic [1:0] ERR_RETRY       = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_TX_BITS,
    ST_LINE_ACK,
    ST_WAIT_RESP,
    ST_DONE
  } state_t;

  // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [9:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_cmd_ctrl_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line, plus a falling-edge strobe from a third flop.
module ps2_line_sync (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta, sync, prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, start, clock out a frame, check line ACK, await 0xFA/0xFE.
module ps2_host_cmd_ctrl
  import ps2_host_cmd_ctrl_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int BIT_TIMEOUT    = 200000,
  parameter int RESP_TIMEOUT   = 2000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       arg_valid,
  input  logic [7:0] arg_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       rx_byte_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_inhibit,
  output logic       done,
  output logic [1:0] err
);

  localparam logic [31:0] INH_LAST  = 32'(INHIBIT_CYCLES - 1);
  localparam logic [31:0] BIT_LAST  = 32'(BIT_TIMEOUT - 1);
  localparam logic [31:0] RESP_LAST = 32'(RESP_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t      state, state_next;
  logic [9:0]  shift_reg;
  logic [3:0]  bit_cnt;
  logic [31:0] timer;
  logic [7:0]  retry_cnt;
  logic [7:0]  cur_byte;
  logic [7:0]  arg_q;
  logic        arg_pending;
  logic [1:0]  err_q;
  logic        data_oe_q;

  logic clk_level, clk_fall, data_level, data_fall;
  logic unused_sync_outputs;

  ps2_line_sync u_clk_sync (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .pin       (ps2_clk_in),
    .level     (clk_level),
    .fall      (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .pin       (ps2_data_in),
    .level     (data_level),
    .fall      (data_fall)
  );

  assign unused_sync_outputs = clk_level ^ data_fall;

  logic tx_phase, bit_expired, resp_expired, got_ack, got_resend, can_retry;
  assign tx_phase     = (state == ST_TX_BITS) || (state == ST_LINE_ACK);
  assign bit_expired  = (timer == BIT_LAST);
  assign resp_expired = (timer == RESP_LAST);
  assign got_ack      = rx_byte_valid && (rx_byte == PS2_ACK);
  assign got_resend   = rx_byte_valid && (rx_byte == PS2_RESEND);
  assign can_retry    = (retry_cnt < RETRY_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Qualifying events are tested before the timeout so a same-cycle event wins.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:      if (cmd_valid) state_next = ST_INHIBIT;
      ST_INHIBIT:   if (timer == INH_LAST) state_next = ST_START;
      ST_START:     state_next = ST_TX_BITS;
      ST_TX_BITS: begin
        if (clk_fall) begin
          if (bit_cnt == 4'd9) state_next = ST_LINE_ACK;
        end else if (bit_expired) begin
          state_next = ST_DONE;
        end
      end
      ST_LINE_ACK: begin
        if (clk_fall)         state_next = data_level ? ST_DONE : ST_WAIT_RESP;
        else if (bit_expired) state_next = ST_DONE;
      end
      ST_WAIT_RESP: begin
        if (got_ack)           state_next = arg_pending ? ST_INHIBIT : ST_DONE;
        else if (got_resend)   state_next = can_retry ? ST_INHIBIT : ST_DONE;
        else if (resp_expired) state_next = ST_DONE;
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    rx_inhibit  = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE:     cmd_ready = 1'b1;
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        rx_inhibit = 1'b1;
      end
      ST_START: begin
        ps2_data_oe = 1'b1;
        rx_inhibit  = 1'b1;
      end
      ST_TX_BITS: begin
        ps2_data_oe = data_oe_q;
        rx_inhibit  = 1'b1;
      end
      ST_LINE_ACK: rx_inhibit = 1'b1;
      ST_DONE:     done = 1'b1;
      default:     ;
    endcase
  end

  assign err = err_q;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      retry_cnt   <= '0;
      cur_byte    <= '0;
      arg_q       <= '0;
      arg_pending <= 1'b0;
      err_q       <= ERR_OK;
      data_oe_q   <= 1'b0;
    end else begin
      // Timer restarts on every state change and on each device clock edge while transmitting.
      if (state == ST_IDLE || state_next != state || (tx_phase && clk_fall)) timer <= '0;
      else                                                               timer <= timer + 32'd1;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cur_byte    <= cmd_byte;
            arg_q       <= arg_byte;
            arg_pending <= arg_valid;
            shift_reg   <= make_frame(cmd_byte);
            retry_cnt   <= '0;
            err_q       <= ERR_OK;
          end
        end
        ST_START: begin
          data_oe_q <= 1'b1;
          bit_cnt   <= '0;
        end
        ST_TX_BITS: begin
          if (clk_fall) begin
            data_oe_q <= ~shift_reg[0];
            shift_reg <= {1'b0, shift_reg[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
          end else if (bit_expired) begin
            err_q <= ERR_TIMEOUT;
          end
        end
        ST_LINE_ACK: begin
          if (clk_fall) begin
            if (data_level) err_q <= ERR_NO_LINE_ACK;
          end else if (bit_expired) begin
            err_q <= ERR_TIMEOUT;
          end
        end
        ST_WAIT_RESP: begin
          if (got_ack) begin
            if (arg_pending) begin
              cur_byte    <= arg_q;
              shift_reg   <= make_frame(arg_q);
              arg_pending <= 1'b0;
              retry_cnt   <= '0;
            end
          end else if (got_resend) begin
            if (can_retry) begin
              retry_cnt <= retry_cnt + 8'd1;
              shift_reg <= make_frame(cur_byte);
            end else begin
              err_q <= ERR_RETRY;
            end
          end else if (resp_expired) begin
            err_q <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Directed bench: a PS/2 device model clocks frames out of the DUT; a scoreboard compares frames and done codes.
module tb_ps2_host_cmd_ctrl;
  import ps2_host_cmd_ctrl_pkg::*;

  localparam int INH  = 20;
  localparam int BTO  = 200;
  localparam int RTO  = 2000;
  localparam int MAXR = 3;
  localparam int HP   = 10;

  logic       CLK100MHZ = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = '0;
  logic       arg_valid = 1'b0;
  logic [7:0] arg_byte = '0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       rx_byte_valid = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_inhibit;
  logic       done;
  logic [1:0] err;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  int checks = 0;
  int failures = 0;
  int done_total = 0;
  int inhibit_cnt = 0;
  logic prev_clk_oe = 1'b0;

  logic [10:0] exp_frame_q[$];
  logic [1:0]  exp_err_q[$];
  logic [1:0]  obs_err_q[$];

  ps2_host_cmd_ctrl #(
    .INHIBIT_CYCLES (INH),
    .BIT_TIMEOUT    (BTO),
    .RESP_TIMEOUT   (RTO),
    .MAX_RETRY      (MAXR)
  ) dut (
    .CLK100MHZ     (CLK100MHZ),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_byte      (cmd_byte),
    .arg_valid     (arg_valid),
    .arg_byte      (arg_byte),
    .ps2_clk_in    (ps2_clk_in),
    .ps2_data_in   (ps2_data_in),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_data_oe   (ps2_data_oe),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte       (rx_byte),
    .rx_inhibit    (rx_inhibit),
    .done          (done),
    .err           (err)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  always @(negedge CLK100MHZ) begin
    if (done) begin
      obs_err_q.push_back(err);
      done_total <= done_total + 1;
    end
    if (ps2_clk_oe && !prev_clk_oe) inhibit_cnt <= inhibit_cnt + 1;
    prev_clk_oe <= ps2_clk_oe;
  end

  // Start bit, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] c, input logic av, input logic [7:0] a);
    @(negedge CLK100MHZ);
    cmd_byte  = c;
    arg_valid = av;
    arg_byte  = a;
    cmd_valid = 1'b1;
    @(negedge CLK100MHZ);
    cmd_valid = 1'b0;
    check("cmd_ready_drop", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic respond(input logic [7:0] b);
    @(negedge CLK100MHZ);
    check("rx_inhibit_resp", {31'd0, rx_inhibit}, 32'd0);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(negedge CLK100MHZ);
    rx_byte_valid = 1'b0;
  endtask

  // Device model: waits for inhibit then start, clocks nbits, then (full frame only) the ACK bit.
  task automatic dev_frame(input int nbits, input bit ack, input bit poke,
                           output logic [10:0] bits, output bit ok);
    int n;
    ok   = 1'b0;
    bits = '0;
    n    = 0;
    while (!ps2_clk_oe && n < INH * 4) begin
      @(negedge CLK100MHZ);
      n++;
    end
    n = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && n < INH * 4) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (n >= INH * 4) return;
    check("rx_inhibit_tx", {31'd0, rx_inhibit}, 32'd1);
    bits[0] = ps2_data_in;
    repeat (HP) @(negedge CLK100MHZ);
    for (int k = 1; k <= nbits; k++) begin
      dev_clk   = 1'b0;
      cmd_valid = poke && (k == 5);
      @(negedge CLK100MHZ);
      cmd_valid = 1'b0;
      repeat (HP - 1) @(negedge CLK100MHZ);
      bits[k] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HP) @(negedge CLK100MHZ);
    end
    if (nbits == 10) begin
      dev_data = !ack;
      repeat (2) @(negedge CLK100MHZ);
      dev_clk = 1'b0;
      repeat (HP) @(negedge CLK100MHZ);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (HP) @(negedge CLK100MHZ);
    end
    ok = 1'b1;
  endtask

  task automatic check_frame(input logic [10:0] bits, input bit ok);
    check("frame_start_seen", {31'd0, ok}, 32'd1);
    if (exp_frame_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
    else                         check("frame_bits", {21'd0, bits}, {21'd0, exp_frame_q.pop_front()});
  endtask

  task automatic wait_done(input int budget);
    int n;
    logic [1:0] exp_e;
    n = 0;
    while (obs_err_q.size() == 0 && n < budget) begin
      @(negedge CLK100MHZ);
      n++;
    end
    exp_e = (exp_err_q.size() != 0) ? exp_err_q.pop_front() : 2'bxx;
    if (obs_err_q.size() == 0) check("done_seen", 32'd0, 32'd1);
    else                       check("done_err", {30'd0, obs_err_q.pop_front()}, {30'd0, exp_e});
  endtask

  initial begin
    logic [10:0] bits;
    bit ok;
    int inh_before, done_before;

    repeat (3) @(negedge CLK100MHZ);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("rst_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);
    check("rst_done_err", {29'd0, done, err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge CLK100MHZ);

    // LED command with argument: two frames, each ACKed.
    exp_frame_q.push_back(frame_of(PS2_CMD_LED));
    exp_frame_q.push_back(frame_of(8'h02));
    exp_err_q.push_back(ERR_OK);
    issue(PS2_CMD_LED, 1'b1, 8'h02);
    dev_frame(10, 1'b1, 1'b0, bits, ok);
    check_frame(bits, ok);
    respond(PS2_ACK);
    dev_frame(10, 1'b1, 1'b0, bits, ok);
    check_frame(bits, ok);
    respond(PS2_ACK);
    wait_done(100);

    // Reset command, resent twice before ACK.
    for (int i = 0; i < 3; i++) exp_frame_q.push_back(frame_of(PS2_CMD_RESET));
    exp_err_q.push_back(ERR_OK);
    issue(PS2_CMD_RESET, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      dev_frame(10, 1'b1, 1'b0, bits, ok);
      check_frame(bits, ok);
      respond((i < 2) ? PS2_RESEND : PS2_ACK);
    end
    wait_done(100);

    // Resend four times: retries exhausted.
    for (int i = 0; i < 4; i++) exp_frame_q.push_back(frame_of(8'hF4));
    exp_err_q.push_back(ERR_RETRY);
    issue(8'hF4, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      dev_frame(10, 1'b1, 1'b0, bits, ok);
      check_frame(bits, ok);
      respond(PS2_RESEND);
    end
    wait_done(100);

    // Device stops clocking after bit 4.
    exp_err_q.push_back(ERR_TIMEOUT);
    issue(8'hF5, 1'b0, 8'h00);
    dev_frame(4, 1'b1, 1'b0, bits, ok);
    check("timeout_start_seen", {31'd0, ok}, 32'd1);
    wait_done(BTO + 100);
    check("timeout_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("timeout_rx_inhibit", {31'd0, rx_inhibit}, 32'd0);

    // No line ACK; a second request during TX must be ignored.
    exp_frame_q.push_back(frame_of(8'hEE));
    exp_err_q.push_back(ERR_NO_LINE_ACK);
    inh_before = inhibit_cnt;
    issue(8'hEE, 1'b0, 8'h00);
    dev_frame(10, 1'b0, 1'b1, bits, ok);
    check_frame(bits, ok);
    wait_done(100);
    repeat (INH * 3) @(negedge CLK100MHZ);
    check("single_frame", inhibit_cnt - inh_before, 32'd1);
    check("idle_after_noack", {31'd0, cmd_ready}, 32'd1);

    // Reset in the middle of TX_BITS.
    done_before = done_total;
    issue(8'hF3, 1'b0, 8'h00);
    dev_frame(3, 1'b1, 1'b0, bits, ok);
    check("rst_mid_start_seen", {31'd0, ok}, 32'd1);
    check("rst_mid_busy", {29'd0, cmd_ready, rx_inhibit, ps2_data_oe}, {29'd0, 1'b0, 1'b1, ~bits[3]});
    @(negedge CLK100MHZ);
    rst = 1'b1;
    @(posedge CLK100MHZ);
    #1;
    check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge CLK100MHZ);
    rst = 1'b0;
    repeat (BTO + 50) @(negedge CLK100MHZ);
    check("rst_mid_no_done", done_total - done_before, 32'd0);
    check("scoreboard_drained", exp_frame_q.size() + exp_err_q.size() + obs_err_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
